// File: rtl/ama_riscv_uart.sv
// Byte-wide 8N1 UART: store-side TX handshake, load-side RX handshake.
// TX and RX run as independent FSMs in the single core clock domain.
module ama_riscv_uart #(
   parameter int unsigned CLOCK_FREQ = 50_000_000,
   parameter int unsigned BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       data_in_valid,
   output logic       data_in_ready,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   input  logic       data_out_ready,
   input  logic       serial_in,
   output logic       serial_out,
   output logic       rx_frame_err,
   output logic       rx_overrun
);

   localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
   localparam int unsigned CW = (SYMBOL_EDGE_TIME > 2) ? $clog2(SYMBOL_EDGE_TIME) : 1;
   localparam logic [CW-1:0] CYC_LAST = CW'(SYMBOL_EDGE_TIME - 1);
   localparam logic [CW-1:0] CYC_MID  = CW'(SAMPLE_TIME - 1);

   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   tx_state_t     tx_state, tx_state_nxt;
   logic [9:0]    tx_shift, tx_shift_nxt;
   logic [3:0]    tx_bit, tx_bit_nxt;
   logic [CW-1:0] tx_cyc, tx_cyc_nxt;
   logic          serial_out_nxt, data_in_ready_nxt;

   rx_state_t     rx_state, rx_state_nxt;
   logic [7:0]    rx_shift, rx_shift_nxt;
   logic [3:0]    rx_bit, rx_bit_nxt;
   logic [CW-1:0] rx_cyc, rx_cyc_nxt;
   logic          rx_m, rx_s;
   logic [7:0]    data_out_nxt;
   logic          data_out_valid_nxt, rx_frame_err_nxt, rx_overrun_nxt;

   // TX state register
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state      <= TX_IDLE;
         tx_shift      <= 10'h3ff;
         tx_bit        <= 4'd0;
         tx_cyc        <= '0;
         serial_out    <= 1'b1;
         data_in_ready <= 1'b1;
      end else begin
         tx_state      <= tx_state_nxt;
         tx_shift      <= tx_shift_nxt;
         tx_bit        <= tx_bit_nxt;
         tx_cyc        <= tx_cyc_nxt;
         serial_out    <= serial_out_nxt;
         data_in_ready <= data_in_ready_nxt;
      end
   end

   // TX next state; serial_out is registered so it tracks what shift[0] will be
   always_comb begin
      tx_state_nxt      = tx_state;
      tx_shift_nxt      = tx_shift;
      tx_bit_nxt        = tx_bit;
      tx_cyc_nxt        = tx_cyc;
      serial_out_nxt    = serial_out;
      data_in_ready_nxt = data_in_ready;
      case (tx_state)
         TX_IDLE: begin
            serial_out_nxt    = 1'b1;
            data_in_ready_nxt = 1'b1;
            if (data_in_valid && data_in_ready) begin
               tx_state_nxt      = TX_SEND;
               tx_shift_nxt      = {1'b1, data_in, 1'b0};
               tx_bit_nxt        = 4'd0;
               tx_cyc_nxt        = '0;
               serial_out_nxt    = 1'b0;
               data_in_ready_nxt = 1'b0;
            end
         end
         TX_SEND: begin
            if (tx_cyc == CYC_LAST) begin
               tx_cyc_nxt   = '0;
               tx_shift_nxt = {1'b1, tx_shift[9:1]};
               tx_bit_nxt   = tx_bit + 4'd1;
               if (tx_bit == 4'd9) begin
                  tx_state_nxt      = TX_IDLE;
                  serial_out_nxt    = 1'b1;
                  data_in_ready_nxt = 1'b1;
               end else begin
                  serial_out_nxt = tx_shift[1];
               end
            end else begin
               tx_cyc_nxt = tx_cyc + CW'(1);
            end
         end
         default: tx_state_nxt = TX_IDLE;
      endcase
   end

   // RX line synchronizer and state register
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m           <= 1'b1;
         rx_s           <= 1'b1;
         rx_state       <= RX_IDLE;
         rx_shift       <= 8'h00;
         rx_bit         <= 4'd0;
         rx_cyc         <= '0;
         data_out       <= 8'h00;
         data_out_valid <= 1'b0;
         rx_frame_err   <= 1'b0;
         rx_overrun     <= 1'b0;
      end else begin
         rx_m           <= serial_in;
         rx_s           <= rx_m;
         rx_state       <= rx_state_nxt;
         rx_shift       <= rx_shift_nxt;
         rx_bit         <= rx_bit_nxt;
         rx_cyc         <= rx_cyc_nxt;
         data_out       <= data_out_nxt;
         data_out_valid <= data_out_valid_nxt;
         rx_frame_err   <= rx_frame_err_nxt;
         rx_overrun     <= rx_overrun_nxt;
      end
   end

   // RX next state; a completed byte takes priority over a same-cycle consume
   always_comb begin
      rx_state_nxt       = rx_state;
      rx_shift_nxt       = rx_shift;
      rx_bit_nxt         = rx_bit;
      rx_cyc_nxt         = rx_cyc;
      data_out_nxt       = data_out;
      data_out_valid_nxt = data_out_valid && !data_out_ready;
      rx_frame_err_nxt   = 1'b0;
      rx_overrun_nxt     = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (!rx_s) begin
               rx_state_nxt = RX_START;
               rx_cyc_nxt   = '0;
            end
         end
         RX_START: begin
            if (rx_cyc == CYC_MID) begin
               rx_cyc_nxt   = '0;
               rx_bit_nxt   = 4'd0;
               rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
            end else begin
               rx_cyc_nxt = rx_cyc + CW'(1);
            end
         end
         RX_DATA: begin
            if (rx_cyc == CYC_LAST) begin
               rx_cyc_nxt   = '0;
               rx_shift_nxt = {rx_s, rx_shift[7:1]};
               rx_bit_nxt   = rx_bit + 4'd1;
               if (rx_bit == 4'd7) rx_state_nxt = RX_STOP;
            end else begin
               rx_cyc_nxt = rx_cyc + CW'(1);
            end
         end
         RX_STOP: begin
            if (rx_cyc == CYC_LAST) begin
               rx_cyc_nxt   = '0;
               rx_state_nxt = RX_IDLE;
               if (rx_s) begin
                  data_out_nxt       = rx_shift;
                  data_out_valid_nxt = 1'b1;
                  rx_overrun_nxt     = data_out_valid && !data_out_ready;
               end else begin
                  rx_frame_err_nxt = 1'b1;
               end
            end else begin
               rx_cyc_nxt = rx_cyc + CW'(1);
            end
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ama_riscv_uart.sv
// Directed bench for ama_riscv_uart at 10 cycles per bit.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_ama_riscv_uart;

   localparam int unsigned CLOCK_FREQ = 1000;
   localparam int unsigned BAUD_RATE  = 100;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_in;
   logic       data_in_valid;
   logic       data_in_ready;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       data_out_ready;
   logic       serial_in;
   logic       serial_out;
   logic       rx_frame_err;
   logic       rx_overrun;
   logic       loop;
   logic       rx_drv;

   int checks   = 0;
   int failures = 0;
   int fe_cnt   = 0;
   int ov_cnt   = 0;

   ama_riscv_uart #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
      .clk           (clk),
      .rst           (rst),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .data_in_ready (data_in_ready),
      .data_out      (data_out),
      .data_out_valid(data_out_valid),
      .data_out_ready(data_out_ready),
      .serial_in     (serial_in),
      .serial_out    (serial_out),
      .rx_frame_err  (rx_frame_err),
      .rx_overrun    (rx_overrun)
   );

   always #5 clk = ~clk;
   assign serial_in = loop ? serial_out : rx_drv;

   // Count error-pulse cycles so each test can require exactly one
   always @(negedge clk) begin
      if (rx_frame_err === 1'b1) fe_cnt++;
      if (rx_overrun === 1'b1) ov_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sends one byte and checks the line level and busy flag every cycle
   task automatic tx_frame_check(input logic [7:0] b, input bit poke);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      data_in       = b;
      data_in_valid = 1'b1;
      step();
      data_in_valid = 1'b0;
      for (int k = 0; k < 100; k++) begin
         check("tx_line", 32'(serial_out), 32'(f[k / 10]));
         check("tx_busy", 32'(data_in_ready), 32'd0);
         if (poke && k == 50) begin
            data_in       = 8'hFF;
            data_in_valid = 1'b1;
         end else begin
            data_in_valid = 1'b0;
         end
         step();
      end
      check("tx_ready_back", 32'(data_in_ready), 32'd1);
      for (int k = 0; k < 15; k++) begin
         check("tx_idle_line", 32'(serial_out), 32'd1);
         step();
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_drv = f[i];
         repeat (10) step();
      end
      rx_drv = 1'b1;
      repeat (20) step();
   endtask

   initial begin
      logic [7:0] got[$];
      logic [9:0] rxf;
      int fe0, ov0, rise, fall;
      bit any_valid;

      rst = 1'b1; data_in = 8'h00; data_in_valid = 1'b0; data_out_ready = 1'b0;
      loop = 1'b0; rx_drv = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();
      check("rst_serial_out", 32'(serial_out), 32'd1);
      check("rst_ready", 32'(data_in_ready), 32'd1);
      check("rst_data_out", 32'(data_out), 32'h00);
      check("rst_valid", 32'(data_out_valid), 32'd0);
      check("rst_frame_err", 32'(rx_frame_err), 32'd0);
      check("rst_overrun", 32'(rx_overrun), 32'd0);

      // 1: TX 0xA5 with an ignored request mid-frame
      tx_frame_check(8'hA5, 1'b1);

      // 2: RX 0x3C then consume
      fe0 = fe_cnt; ov0 = ov_cnt;
      send_frame(8'h3C, 1'b1);
      check("rx3c_valid", 32'(data_out_valid), 32'd1);
      check("rx3c_data", 32'(data_out), 32'h3C);
      check("rx3c_no_fe", 32'(fe_cnt - fe0), 32'd0);
      check("rx3c_no_ov", 32'(ov_cnt - ov0), 32'd0);
      data_out_ready = 1'b1;
      step();
      data_out_ready = 1'b0;
      check("consume_clears", 32'(data_out_valid), 32'd0);

      // 3: loopback back-to-back 0x00 then 0xFF
      fe0 = fe_cnt; ov0 = ov_cnt;
      loop = 1'b1;
      data_in = 8'h00; data_in_valid = 1'b1;
      step();
      data_in = 8'hFF;
      rise = -1; fall = -1;
      for (int i = 0; i < 260; i++) begin
         if (data_out_ready) data_out_ready = 1'b0;
         else if (data_out_valid) begin
            got.push_back(data_out);
            data_out_ready = 1'b1;
         end
         if (rise < 0 && data_in_ready) rise = i;
         if (rise >= 0 && fall < 0 && !data_in_ready) begin
            fall = i;
            data_in_valid = 1'b0;
            check("b2b_start_bit", 32'(serial_out), 32'd0);
         end
         step();
      end
      data_out_ready = 1'b0;
      loop = 1'b0;
      check("b2b_busy_cycles", 32'(rise), 32'd100);
      check("b2b_ready_cycles", 32'(fall - rise), 32'd1);
      check("loop_count", 32'(got.size()), 32'd2);
      if (got.size() >= 2) begin
         check("loop_byte0", 32'(got[0]), 32'h00);
         check("loop_byte1", 32'(got[1]), 32'hFF);
      end
      check("loop_no_fe", 32'(fe_cnt - fe0), 32'd0);
      check("loop_no_ov", 32'(ov_cnt - ov0), 32'd0);

      // 4: 3-cycle glitch is a false start, then 0x81
      fe0 = fe_cnt; ov0 = ov_cnt;
      rx_drv = 1'b0;
      repeat (3) step();
      rx_drv = 1'b1;
      repeat (30) step();
      check("glitch_no_valid", 32'(data_out_valid), 32'd0);
      check("glitch_no_pulse", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);
      send_frame(8'h81, 1'b1);
      check("rx81_valid", 32'(data_out_valid), 32'd1);
      check("rx81_data", 32'(data_out), 32'h81);
      data_out_ready = 1'b1;
      step();
      data_out_ready = 1'b0;

      // 5: framing error, then overrun
      fe0 = fe_cnt; ov0 = ov_cnt;
      send_frame(8'h55, 1'b0);
      check("fe_pulse_cycles", 32'(fe_cnt - fe0), 32'd1);
      check("fe_no_valid", 32'(data_out_valid), 32'd0);
      send_frame(8'h12, 1'b1);
      check("rx12_data", 32'(data_out), 32'h12);
      check("rx12_no_ov", 32'(ov_cnt - ov0), 32'd0);
      send_frame(8'h34, 1'b1);
      check("ov_pulse_cycles", 32'(ov_cnt - ov0), 32'd1);
      check("ov_data", 32'(data_out), 32'h34);
      check("ov_valid", 32'(data_out_valid), 32'd1);
      data_out_ready = 1'b1;
      step();
      data_out_ready = 1'b0;

      // 6: reset mid-TX of 0xF0 and mid-RX of 0x0F
      fe0 = fe_cnt; ov0 = ov_cnt;
      rxf = {1'b1, 8'h0F, 1'b0};
      data_in = 8'hF0; data_in_valid = 1'b1; rx_drv = 1'b0;
      step();
      data_in_valid = 1'b0;
      for (int i = 1; i < 60; i++) begin
         if (i == 35) begin
            check("pre_rst_line", 32'(serial_out), 32'd0);
            rst = 1'b1;
         end
         if (i == 36) begin
            check("mid_rst_line", 32'(serial_out), 32'd1);
            check("mid_rst_ready", 32'(data_in_ready), 32'd1);
            check("mid_rst_data_out", 32'(data_out), 32'h00);
            rst = 1'b0;
         end
         rx_drv = (i < 35) ? rxf[i / 10] : 1'b1;
         step();
      end
      any_valid = 1'b0;
      for (int i = 0; i < 150; i++) begin
         if (data_out_valid) any_valid = 1'b1;
         step();
      end
      check("rst_no_byte", 32'(any_valid), 32'd0);
      check("rst_no_pulse", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);
      tx_frame_check(8'h5A, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
